// File: rtl/div_period_checker.sv
// div_period_checker: measures high/low widths of a divided clock and flags mismatches.
//
// Samples div_in (a signal generated from clk) through two flops and times each
// high and low phase in clk cycles. Every completed period (rise to rise) is
// published on the following cycle and compared against EXP_HIGH/EXP_LOW.
//
// Ports:
//   clk        single clock, all state changes on its rising edge
//   reset      asynchronous active-high reset
//   div_in     divided-clock input from the upstream divider
//   enable     level-sensitive measurement enable
//   clr_err    synchronous one-cycle clear of err
//   high_cnt   high width of the last completed period
//   low_cnt    low width of the last completed period
//   period     high_cnt + low_cnt of the last completed period
//   meas_valid one-cycle pulse when high_cnt/low_cnt/period update
//   duty_ok    last measurement matched EXP_HIGH and EXP_LOW
//   err        sticky error flag
//   locked     two consecutive matching periods seen
module div_period_checker #(
    parameter int CNT_W    = 7,
    parameter int EXP_HIGH = 6,
    parameter int EXP_LOW  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_in,
    input  logic             enable,
    input  logic             clr_err,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic [CNT_W:0]   period,
    output logic             meas_valid,
    output logic             duty_ok,
    output logic             err,
    output logic             locked
);
    typedef enum logic [1:0] {IDLE, SYNC, HIGH, LOW} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] NEAR_MAX = CNT_MAX - 1'b1;
    localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] EXP_H    = EXP_HIGH[CNT_W-1:0];
    localparam logic [CNT_W-1:0] EXP_L    = EXP_LOW[CNT_W-1:0];

    state_t           state;
    logic             s, p;
    logic             rise, fall, match;
    logic             prev_ok;
    logic [CNT_W-1:0] h, l;

    assign rise  = s & ~p;
    assign fall  = ~s & p;
    assign match = (h == EXP_H) && (l == EXP_L);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            s          <= 1'b0;
            p          <= 1'b0;
            h          <= '0;
            l          <= '0;
            prev_ok    <= 1'b0;
            high_cnt   <= '0;
            low_cnt    <= '0;
            period     <= '0;
            meas_valid <= 1'b0;
            duty_ok    <= 1'b0;
            err        <= 1'b0;
            locked     <= 1'b0;
        end else begin
            s          <= div_in;
            p          <= s;
            meas_valid <= 1'b0;
            // Any error-setting assignment below comes later and therefore wins.
            if (clr_err)
                err <= 1'b0;
            if (!enable) begin
                // Enable dominates: a completion in this same cycle is dropped.
                state   <= IDLE;
                h       <= '0;
                l       <= '0;
                locked  <= 1'b0;
                prev_ok <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= SYNC;
                        h     <= '0;
                        l     <= '0;
                    end
                    SYNC: begin
                        if (rise) begin
                            state <= HIGH;
                            h     <= ONE;
                        end
                    end
                    HIGH: begin
                        if (fall) begin
                            state <= LOW;
                            l     <= ONE;
                        end else if (h == NEAR_MAX) begin
                            // Stuck-high: resynchronise without publishing.
                            state   <= SYNC;
                            h       <= CNT_MAX;
                            err     <= 1'b1;
                            locked  <= 1'b0;
                            prev_ok <= 1'b0;
                        end else begin
                            h <= h + 1'b1;
                        end
                    end
                    LOW: begin
                        if (rise) begin
                            // Period complete; the rise also opens the next high phase.
                            state      <= HIGH;
                            h          <= ONE;
                            high_cnt   <= h;
                            low_cnt    <= l;
                            period     <= {1'b0, h} + {1'b0, l};
                            meas_valid <= 1'b1;
                            duty_ok    <= match;
                            prev_ok    <= match;
                            locked     <= match & prev_ok;
                            if (!match)
                                err <= 1'b1;
                        end else if (l == NEAR_MAX) begin
                            // Stuck-low: resynchronise without publishing.
                            state   <= SYNC;
                            l       <= CNT_MAX;
                            err     <= 1'b1;
                            locked  <= 1'b0;
                            prev_ok <= 1'b0;
                        end else begin
                            l <= l + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_div_period_checker.sv
// tb_div_period_checker: directed self-checking bench for div_period_checker.
`timescale 1ns/1ps
module tb_div_period_checker;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       div_in = 1'b0;
    logic       enable = 1'b0;
    logic       clr_err = 1'b0;
    logic [6:0] high_cnt, low_cnt;
    logic [7:0] period;
    logic       meas_valid, duty_ok, err, locked;
    logic       div_in2 = 1'b0;
    logic       enable2 = 1'b0;
    logic [6:0] high_cnt2, low_cnt2;
    logic [7:0] period2;
    logic       meas_valid2, duty_ok2, err2, locked2;
    int         checks = 0;
    int         errors = 0;
    int         mv = 0;
    int         mv2 = 0;
    int         base = 0;

    div_period_checker dut (
        .clk(clk), .reset(reset), .div_in(div_in), .enable(enable), .clr_err(clr_err),
        .high_cnt(high_cnt), .low_cnt(low_cnt), .period(period), .meas_valid(meas_valid),
        .duty_ok(duty_ok), .err(err), .locked(locked)
    );

    div_period_checker #(.CNT_W(7), .EXP_HIGH(5), .EXP_LOW(4)) dut2 (
        .clk(clk), .reset(reset), .div_in(div_in2), .enable(enable2), .clr_err(1'b0),
        .high_cnt(high_cnt2), .low_cnt(low_cnt2), .period(period2), .meas_valid(meas_valid2),
        .duty_ok(duty_ok2), .err(err2), .locked(locked2)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (meas_valid)
            mv++;
        if (meas_valid2)
            mv2++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic v);
        div_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc2(input logic v);
        div_in2 = v;
        @(posedge clk);
        #1;
    endtask

    task automatic wave(input int hi, input int lo);
        for (int i = 0; i < hi; i++) cyc(1'b1);
        for (int i = 0; i < lo; i++) cyc(1'b0);
    endtask

    task automatic wave2(input int hi, input int lo);
        for (int i = 0; i < hi; i++) cyc2(1'b1);
        for (int i = 0; i < lo; i++) cyc2(1'b0);
    endtask

    task automatic meas(input string tag, input int h, input int l, input int ok, input int lk);
        check({tag, "_high"}, high_cnt, h);
        check({tag, "_low"}, low_cnt, l);
        check({tag, "_period"}, period, h + l);
        check({tag, "_duty"}, duty_ok, ok);
        check({tag, "_locked"}, locked, lk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {high_cnt, low_cnt, period, meas_valid, duty_ok, err, locked}, 0);
        reset = 1'b0;
        // 5/4 divider against a 5/4 checker
        enable2 = 1'b1;
        repeat (2) cyc2(1'b0);
        wave2(5, 4);
        wave2(5, 4);
        wave2(5, 4);
        check("d2_mv", mv2, 2);
        check("d2_high", high_cnt2, 5);
        check("d2_low", low_cnt2, 4);
        check("d2_period", period2, 9);
        check("d2_duty", duty_ok2, 1);
        check("d2_locked", locked2, 1);
        check("d2_err", err2, 0);
        enable2 = 1'b0;
        check("idle_mv", mv, 0);
        // 6/6 stream and lock
        enable = 1'b1;
        repeat (2) cyc(1'b0);
        wave(6, 6);
        check("a_mv_first", mv, 0);
        wave(6, 6);
        check("a_mv1", mv, 1);
        meas("a1", 6, 6, 1, 0);
        check("a1_err", err, 0);
        wave(6, 6);
        check("a_mv2", mv, 2);
        meas("a2", 6, 6, 1, 1);
        // one bad 7/5 period
        wave(7, 5);
        meas("b0", 6, 6, 1, 1);
        wave(6, 6);
        check("b_mv", mv, 4);
        meas("b1", 7, 5, 0, 0);
        check("b1_err", err, 1);
        wave(6, 6);
        meas("b2", 6, 6, 1, 0);
        check("b2_err", err, 1);
        wave(6, 6);
        meas("b3", 6, 6, 1, 1);
        check("b3_err", err, 1);
        // stuck high for 130 cycles; clr_err collides with the saturation edge
        base = mv;
        for (int i = 0; i < 130; i++) begin
            clr_err = (i == 0 || i == 127);
            cyc(1'b1);
            clr_err = 1'b0;
            if (i == 0)
                check("c_clr", err, 0);
            if (i == 126) begin
                check("c_pre_sat_err", err, 0);
                check("c_mv_pre", mv, base + 1);
            end
            if (i == 127)
                check("c_sat_err", err, 1);
        end
        check("c_mv_stuck", mv, base + 1);
        meas("c", 6, 6, 1, 0);
        // resync after stuck
        repeat (4) cyc(1'b0);
        wave(6, 6);
        wave(6, 6);
        check("d_mv", mv, base + 2);
        meas("d1", 6, 6, 1, 0);
        wave(6, 6);
        meas("d2", 6, 6, 1, 1);
        check("d2_err", err, 1);
        // drop enable mid-high, re-enable while still high
        wave(5, 5);
        repeat (3) cyc(1'b1);
        meas("e0", 5, 5, 0, 0);
        base = mv;
        enable = 1'b0;
        repeat (4) cyc(1'b1);
        check("e_mv_off", mv, base);
        meas("e_hold", 5, 5, 0, 0);
        check("e_hold_err", err, 1);
        enable = 1'b1;
        repeat (3) cyc(1'b1);
        repeat (6) cyc(1'b0);
        wave(6, 6);
        wave(6, 6);
        check("e_mv_on", mv, base + 1);
        meas("e1", 6, 6, 1, 0);
        wave(6, 6);
        meas("e2", 6, 6, 1, 1);
        // completion edge coincides with enable falling
        wave(4, 6);
        base = mv;
        cyc(1'b1);
        enable = 1'b0;
        repeat (3) cyc(1'b1);
        check("f_mv", mv, base);
        meas("f", 6, 6, 1, 0);
        // async reset mid-low
        enable = 1'b1;
        repeat (2) cyc(1'b0);
        wave(6, 6);
        wave(6, 6);
        repeat (6) cyc(1'b1);
        repeat (3) cyc(1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("g_async", {high_cnt, low_cnt, period, meas_valid, duty_ok, err, locked}, 0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        base = mv;
        repeat (2) cyc(1'b0);
        wave(6, 6);
        wave(6, 6);
        wave(6, 6);
        check("g_mv", mv, base + 2);
        meas("g", 6, 6, 1, 1);
        check("g_err", err, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
